// File: rtl/snn_result_reporter.sv
// Per-class spike accumulator with a sequential argmax scan. The result and a
// 16-bit run/done status word are published from registered outputs.
module snn_result_reporter #(
  parameter int          NUM_CLASSES = 10,
  parameter int          CNT_W       = 8,
  parameter logic [7:0]  TAG         = 8'hAB,
  parameter int          IDX_W       = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   spike_valid,
  input  logic [NUM_CLASSES-1:0] spike_vec,
  input  logic                   frame_end,
  output logic [15:0]            status_out,
  output logic [15:0]            status_oeb,
  output logic                   busy,
  output logic                   result_valid,
  output logic [IDX_W-1:0]       result_class,
  output logic                   result_none
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt     [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_acc [NUM_CLASSES];
  logic [CNT_W-1:0] max_val;
  logic [IDX_W-1:0] max_idx;
  logic [IDX_W-1:0] scan_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
      cnt_acc[i] = cnt[i];
      if (spike_valid && spike_vec[i] && (cnt[i] != CNT_MAX))
        cnt_acc[i] = cnt[i] + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = ACCUM;
      ACCUM: if (!start && frame_end) state_nxt = SCAN;
      SCAN:  if (scan_idx == LAST_IDX) state_nxt = DONE;
      DONE:  if (start) state_nxt = ACCUM;
      default: state_nxt = IDLE;
    endcase
  end

  // Scan seeds from the post-update counter 0 so the final timestep is included.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
      max_val  <= '0;
      max_idx  <= '0;
      scan_idx <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start)
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
        end
        ACCUM: begin
          if (start) begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= '0;
          end else begin
            for (int unsigned i = 0; i < NUM_CLASSES; i++) cnt[i] <= cnt_acc[i];
            if (frame_end) begin
              max_val  <= cnt_acc[0];
              max_idx  <= '0;
              scan_idx <= IDX_W'(1);
            end
          end
        end
        SCAN: begin
          if (cnt[scan_idx] > max_val) begin
            max_val <= cnt[scan_idx];
            max_idx <= scan_idx;
          end
          scan_idx <= scan_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_out   <= '0;
      status_oeb   <= '1;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_class <= '0;
      result_none  <= 1'b0;
    end else begin
      if (state == IDLE && start) status_oeb <= '0;
      case (state)
        ACCUM, SCAN: status_out <= {TAG, 8'h60};
        DONE:        status_out <= {TAG, 8'h61};
        default:     status_out <= '0;
      endcase
      busy         <= (state == ACCUM) || (state == SCAN);
      result_valid <= (state == DONE);
      result_none  <= (state == DONE) && (max_val == '0);
      if (state == DONE) result_class <= max_idx;
    end
  end

endmodule

// File: tb/tb_snn_result_reporter.sv
// Self-checking bench for snn_result_reporter against a per-frame spike-count model.
module tb_snn_result_reporter;

  localparam int NC    = 10;
  localparam int CMAX  = 255;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          spike_valid = 1'b0;
  logic [NC-1:0] spike_vec = '0;
  logic          frame_end = 1'b0;
  logic [15:0]   status_out;
  logic [15:0]   status_oeb;
  logic          busy;
  logic          result_valid;
  logic [3:0]    result_class;
  logic          result_none;

  int n_checks = 0;
  int n_fail   = 0;
  int model_cnt [NC];

  snn_result_reporter #(.NUM_CLASSES(NC), .CNT_W(8), .TAG(8'hAB), .IDX_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .spike_valid(spike_valid),
    .spike_vec(spike_vec), .frame_end(frame_end), .status_out(status_out),
    .status_oeb(status_oeb), .busy(busy), .result_valid(result_valid),
    .result_class(result_class), .result_none(result_none)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) model_cnt[i] = 0;
  endtask

  // Winner = lowest class holding the maximum count.
  task automatic model_result(output int cls, output bit none);
    int mx;
    mx = 0;
    for (int i = 0; i < NC; i++) if (model_cnt[i] > mx) mx = model_cnt[i];
    cls = 0;
    for (int i = NC - 1; i >= 0; i--) if (model_cnt[i] == mx) cls = i;
    none = (mx == 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [NC-1:0] vec, input bit valid, input bit fe);
    spike_vec   = vec;
    spike_valid = valid;
    frame_end   = fe;
    step();
    spike_valid = 1'b0;
    frame_end   = 1'b0;
    spike_vec   = '0;
    if (valid)
      for (int i = 0; i < NC; i++)
        if (vec[i] && model_cnt[i] < CMAX) model_cnt[i]++;
  endtask

  // Called right after the frame_end edge; optionally pokes start mid-scan.
  task automatic expect_done(input string name, input bit poke_start);
    int cls;
    bit none;
    bit early;
    model_result(cls, none);
    early = 1'b0;
    for (int k = 1; k < NC; k++) begin
      if (poke_start && k == 3) start = 1'b1;
      step();
      start = 1'b0;
      if (result_valid !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL %s latency: result_valid rose before frame_end+%0d", name, NC);
    end
    step();
    n_checks++;
    if (result_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s valid: got %b expected 1", name, result_valid);
    end
    n_checks++;
    if (status_out !== 16'hAB61) begin
      n_fail++;
      $display("FAIL %s status: got %h expected ab61", name, status_out);
    end
    n_checks++;
    if (result_class !== 4'(cls)) begin
      n_fail++;
      $display("FAIL %s class: got %0d expected %0d", name, result_class, cls);
    end
    n_checks++;
    if (result_none !== none) begin
      n_fail++;
      $display("FAIL %s none: got %b expected %b", name, result_none, none);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if ({status_out, status_oeb, busy, result_valid, result_class, result_none}
        !== {16'h0000, 16'hFFFF, 1'b0, 1'b0, 4'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL %s reset: status=%h oeb=%h busy=%b valid=%b class=%0d none=%b expected 0000 ffff 0 0 0 0",
               name, status_out, status_oeb, busy, result_valid, result_class, result_none);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    check_reset_values("test_reset");
    reset_n = 1'b1;
    step();
    check_reset_values("test_reset_idle");
    // Inputs other than start are ignored in IDLE.
    send(10'h3FF, 1'b1, 1'b1);
    model_clear();
    step();
    check_reset_values("test_idle_ignore");
  endtask

  task automatic test_basic();
    do_start();
    for (int t = 0; t < 5; t++) begin
      send(10'b0000001000, 1'b1, t == 4);
      if (t == 1) begin
        n_checks++;
        if (status_out !== 16'hAB60 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL test_basic run status: got %h busy=%b expected ab60 busy=1", status_out, busy);
        end
      end
    end
    expect_done("test_basic", 1'b0);
    n_checks++;
    if (status_oeb !== 16'h0000) begin
      n_fail++;
      $display("FAIL test_basic oeb: got %h expected 0000", status_oeb);
    end
  endtask

  task automatic test_tie();
    do_start();
    for (int t = 0; t < 4; t++) send(10'b0010000100, 1'b1, 1'b0);
    send(10'b0000000001, 1'b1, 1'b1);
    expect_done("test_tie", 1'b0);
  endtask

  task automatic test_saturation();
    do_start();
    for (int t = 0; t < 300; t++)
      send(10'h200 | ((t < 100) ? 10'h001 : 10'h000), 1'b1, t == 299);
    expect_done("test_saturation", 1'b0);
  endtask

  task automatic test_none();
    do_start();
    send(10'h3FF, 1'b0, 1'b1);
    expect_done("test_none", 1'b0);
  endtask

  task automatic test_restart();
    do_start();
    for (int t = 0; t < 3; t++) send(10'b0000000010, 1'b1, 1'b0);
    // start + spike + frame_end together: start wins, spikes discarded
    start = 1'b1;
    send(10'b0000000010, 1'b1, 1'b1);
    start = 1'b0;
    model_clear();
    send(10'b0000010000, 1'b1, 1'b0);
    send(10'b0000010000, 1'b1, 1'b1);
    expect_done("test_restart", 1'b0);
    do_start();
    step();
    n_checks++;
    if (result_valid !== 1'b0 || result_class !== 4'd4 || status_out !== 16'hAB60) begin
      n_fail++;
      $display("FAIL test_restart drop: valid=%b class=%0d status=%h expected 0 4 ab60",
               result_valid, result_class, status_out);
    end
  endtask

  task automatic test_start_in_scan();
    do_start();
    for (int t = 0; t < 6; t++) send(10'b0001000000 | ((t < 2) ? 10'h020 : 10'h0), 1'b1, t == 5);
    expect_done("test_start_in_scan", 1'b1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      int len;
      len = $urandom_range(40, 3);
      do_start();
      for (int t = 0; t < len; t++)
        send(10'($urandom), 1'($urandom), t == len - 1);
      expect_done("test_random", 1'b0);
    end
  endtask

  task automatic test_reset_in_scan();
    do_start();
    for (int t = 0; t < 4; t++) send(10'b0100000000, 1'b1, t == 3);
    step(); step(); step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_values("test_reset_in_scan");
    step();
    reset_n = 1'b1;
    step();
    check_reset_values("test_reset_in_scan_hold");
    do_start();
    for (int t = 0; t < 3; t++) send(10'b0000100000, 1'b1, t == 2);
    expect_done("test_reset_in_scan_after", 1'b0);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_tie();
    test_saturation();
    test_none();
    test_restart();
    test_start_in_scan();
    test_random();
    test_reset_in_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_result_reporter.md
Name: snn_result_reporter

Overview:
- Sits downstream of the SNN neuron-core array inside the user project, and upstream of the mprj_io[31:16] status pins that the chip-level firmware benches poll.
- Counts output-layer spikes per class over one inference frame, then picks the winning class with a sequential argmax scan.
- Publishes a 16-bit status word (run / done codes) plus the classification result.

Parameters:
- NUM_CLASSES, 10, number of output neurons/classes; legal range 2..16.
- CNT_W, 8, width of each per-class spike counter; counters saturate.
- TAG, 8'hAB, upper byte of every non-idle status word.
- IDX_W, 4, width of the class index; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: clear counters and begin a frame.
- spike_valid  in  1  spike_vec is valid this cycle (one SNN timestep).
- spike_vec  in  NUM_CLASSES  output-layer spikes for this timestep; bit i = class i.
- frame_end  in  1  pulse marking the last timestep of the frame.
- status_out  out  16  status word to io_out[31:16].
- status_oeb  out  16  output-enable-bar for io[31:16]; 0 = drive.
- busy  out  1  high in ACCUM and SCAN.
- result_valid  out  1  high in DONE.
- result_class  out  IDX_W  winning class index.
- result_none  out  1  high in DONE when every counter is 0.

Behaviour:
- Reset values:
  - FSM = IDLE; all counters 0.
  - status_out = 16'h0000; status_oeb = 16'hFFFF.
  - busy = 0; result_valid = 0; result_class = 0; result_none = 0.
- status_oeb goes to 16'h0000 on the first start accepted after reset and stays 0 until the next reset.
- FSM states: IDLE, ACCUM, SCAN, DONE. All outputs are registered.
- IDLE:
  - start -> ACCUM; clear all counters.
  - spike_valid and frame_end are ignored.
- ACCUM:
  - status_out = {TAG, 8'h60}.
  - Each cycle with spike_valid = 1: counter[i] += 1 for each set spike_vec[i], saturating at 2^CNT_W - 1.
  - frame_end with spike_valid in the same cycle: that spike vector is counted, then the FSM goes to SCAN.
  - start in ACCUM restarts the frame: counters cleared, the same-cycle spike_vec is discarded, and the FSM stays in ACCUM.
  - start and frame_end in the same cycle: start wins.
- SCAN:
  - Entry: max_val = counter[0], max_idx = 0, scan index = 1.
  - Each cycle compares counter[idx] > max_val (strict greater), so on a tie the lowest index wins; idx then increments.
  - After idx = NUM_CLASSES-1 is compared, go to DONE. SCAN therefore lasts NUM_CLASSES-1 cycles.
  - start, spike_valid and frame_end are ignored in SCAN.
  - status_out holds {TAG, 8'h60}.
- DONE:
  - result_valid = 1; result_class = max_idx.
  - result_none = (max_val == 0).
  - status_out = {TAG, 8'h61}.
  - Counters are held, so a retry without reset is possible.
  - start -> ACCUM with counters cleared; result_valid drops the next cycle; result_class keeps its old value until the next DONE.
- Latency: frame_end accepted at cycle T -> result_valid = 1 and status 16'hAB61 visible at cycle T + NUM_CLASSES (T+10 at the defaults).
- Reset asserted mid-frame or mid-scan returns immediately to the reset values; no partial result is reported.
- Counter width arithmetic is unsigned. Comparison uses the full CNT_W bits.

Test Plan:
- Reset then start; 5 timesteps with spike_vec = 10'b0000001000; frame_end on the 5th -> status 16'hAB60 during the frame; then 16'hAB61, result_class = 3, result_none = 0 exactly 10 cycles after frame_end; status_oeb = 0.
- Tie: class 2 and class 7 each get 4 spikes -> result_class = 2.
- Saturation: 300 timesteps with bit 9 set, bit 0 set on 100 of them -> counter[9] = 255 (saturated), result_class = 9.
- No spikes, start then frame_end -> result_none = 1, result_class = 0, status 16'hAB61.
- Restart and ignore:
  - start mid-ACCUM after 3 class-1 spikes, then 2 class-4 spikes, frame_end -> result_class = 4.
  - start during SCAN is ignored; the scan completes normally.
- reset_n pulled low during SCAN -> outputs return to reset values the same cycle; status_oeb = 16'hFFFF; a following start/frame sequence produces a correct result.
